i2s_in: RTL and testbench
=========================

Name: i2s_in

Overview:
- I2S deserializer for the MCU return path (mcu_sdin). It sits in the adc_clk domain next to the I2S serializer that feeds the DAC and MCU.
- It samples mcu_sdin against the serializer's own sclk/lrclk outputs and recovers signed left/right words.
- It delivers each stereo pair with a one-cycle valid strobe to downstream audio logic (DAC mux/processing).
- It also flags framing errors and reports lock status.

Parameters:
- dsz, 16, data word width per channel (bits captured per half-frame).
- slots, 32, sclk rising edges per half-frame (lrclk high or low period); must satisfy slots >= dsz+1.

Ports:
- clk  input  1  system clock (adc_clk domain); all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- sclk  input  1  I2S bit clock, synchronous to clk (serializer output).
- lrclk  input  1  I2S word select, synchronous to clk; 0 = left, 1 = right.
- sdin  input  1  serial data from MCU pin, asynchronous to clk.
- l_data  output  dsz  signed left word, two's complement.
- r_data  output  dsz  signed right word, two's complement.
- valid  output  1  one-clk pulse: l_data/r_data updated.
- frame_err  output  1  one-clk pulse: half-frame length violation detected.
- locked  output  1  high while framing is aligned.

Behaviour:
Input alignment
- sdin passes through a 2-flop synchronizer.
- sclk and lrclk pass through a matching 2-stage delay so all three stay aligned.
- Edge detection uses a third register on the delayed sclk/lrclk:
  - srise = rising edge of sclk.
  - lredge = any lrclk transition.

Format
- Standard I2S with one-bit delay, MSB first.
- Per half-frame, srise index k counts from 0 at the first sclk rise after an lrclk edge:
  - k=0: delay slot, ignored.
  - k=1..dsz: shift sdin into the channel shift register, MSB first.
  - k>dsz: ignored.
- Bit counter width is clog2(slots+1). It saturates at slots and does not wrap.

State machine
- SYNC (reset state):
  - Ignore data; locked=0.
  - On lredge with new lrclk=0 (falling): clear counter and shift register, go to LEFT.
- LEFT:
  - On lredge: if count==slots, copy shift register to left holding register, clear counter, go to RIGHT.
  - Else: pulse frame_err, go to SYNC.
- RIGHT:
  - On lredge: if count==slots, latch l_data <= left holding register and r_data <= shift register in the same cycle, pulse valid, clear counter, go to LEFT.
  - Else: pulse frame_err, go to SYNC.
- locked=1 in LEFT/RIGHT once at least one valid pulse has been issued since leaving SYNC; otherwise 0.

Boundary rules
- srise and lredge in the same clk:
  - srise is counted first, i.e. before the comparison.
  - The source never produces this; the rule exists only for determinism.
- Counter saturation: an overlong half-frame leaves count at slots. The next lredge still passes, so frames with more than slots rises are not flagged beyond saturation.
- An lredge arriving early (count<slots) is always an error. No partial data is emitted; l_data/r_data keep their previous values.
- valid and frame_err are never high in the same cycle.
- Outputs change only on valid.

Latency
- valid asserts 4 clk after the lrclk falling edge at the pin: 2 synchronizer/delay stages, 1 edge-detect stage, 1 output register.

Reset
- All outputs 0 (l_data, r_data, valid, frame_err, locked).
- State SYNC; counter, shift register and holding register 0.
- Synchronizer and delay stages 0.
- Reset mid-frame discards partial data. After release the block waits for the next lrclk falling edge.

Test Plan:
1. Normal frame: dsz=16, slots=32, sclk = clk/8. MCU sends L=16'h8001, R=16'h7FFE.
   - Expect: valid pulses once per frame, 4 clk after lrclk falls; l_data=16'h8001, r_data=16'h7FFE; locked=1 after the first valid.
2. Startup mid-frame: release reset while lrclk=1, partway through a right half-frame.
   - Expect: no valid until one full L+R pair is received; the first pair output is correct; frame_err stays 0.
3. Short half-frame: one left half-frame with only 20 sclk rises.
   - Expect: frame_err one pulse at that lrclk edge; locked=0; state SYNC; l_data/r_data unchanged; relock on the next falling lrclk; correct data on the following frame.
4. Back-to-back sweep: 64 consecutive frames with incrementing L (16'h0000..16'h003F) and R = ~L.
   - Expect: 64 valid pulses, spacing exactly 2*slots*8 clk, all values match.
5. Extremes/bit order: L=16'h0001, R=16'hFFFF, then L=16'h8000, R=16'h0000.
   - Expect: exact values, confirming MSB-first order and the one-bit delay.
6. Reset mid-operation: assert reset during bit 8 of the right channel.
   - Expect: outputs go to 0 immediately (async); no spurious valid after release; the next full frame decodes correctly.

Source files
------------

// File: rtl/i2s_in.sv
// I2S deserializer: recovers signed left/right words from sdin against local sclk/lrclk,
// emits one valid pulse per stereo pair, flags half-frame length errors and reports lock.
module i2s_in #(
    parameter int dsz   = 16,
    parameter int slots = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sclk,
    input  logic                  lrclk,
    input  logic                  sdin,
    output logic signed [dsz-1:0] l_data,
    output logic signed [dsz-1:0] r_data,
    output logic                  valid,
    output logic                  frame_err,
    output logic                  locked
);

    localparam int cw = $clog2(slots + 1);

    typedef enum logic [1:0] {SYNC, LEFT, RIGHT} state_t;

    state_t           state;
    logic [1:0]       sd_sync;
    logic [1:0]       sclk_dly;
    logic [1:0]       lr_dly;
    logic             sclk_d3;
    logic             lr_d3;
    logic             srise;
    logic             lredge;
    logic             lr_new;
    logic             bit_in;
    logic [cw-1:0]    cnt;
    logic [cw-1:0]    cnt_adv;
    logic [dsz-1:0]   shreg;
    logic [dsz-1:0]   shift_adv;
    logic [dsz-1:0]   hold;

    // Edge pulses and the data bit are registered together so they stay aligned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sd_sync  <= '0;
            sclk_dly <= '0;
            lr_dly   <= '0;
            sclk_d3  <= 1'b0;
            lr_d3    <= 1'b0;
            srise    <= 1'b0;
            lredge   <= 1'b0;
            lr_new   <= 1'b0;
            bit_in   <= 1'b0;
        end else begin
            sd_sync  <= {sd_sync[0], sdin};
            sclk_dly <= {sclk_dly[0], sclk};
            lr_dly   <= {lr_dly[0], lrclk};
            sclk_d3  <= sclk_dly[1];
            lr_d3    <= lr_dly[1];
            srise    <= sclk_dly[1] & ~sclk_d3;
            lredge   <= lr_dly[1] ^ lr_d3;
            lr_new   <= lr_dly[1];
            bit_in   <= sd_sync[1];
        end
    end

    // A rise coinciding with an lrclk edge is folded in before the length check.
    always_comb begin
        cnt_adv   = cnt;
        shift_adv = shreg;
        if (srise) begin
            if (cnt != cw'(slots)) begin
                cnt_adv = cnt + cw'(1);
            end
            if (cnt >= cw'(1) && cnt <= cw'(dsz)) begin
                shift_adv = {shreg[dsz-2:0], bit_in};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SYNC;
            cnt       <= '0;
            shreg     <= '0;
            hold      <= '0;
            l_data    <= '0;
            r_data    <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            locked    <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            cnt       <= cnt_adv;
            shreg     <= shift_adv;
            case (state)
                SYNC: begin
                    if (lredge && !lr_new) begin
                        cnt   <= '0;
                        shreg <= '0;
                        state <= LEFT;
                    end
                end
                LEFT: begin
                    if (lredge) begin
                        if (cnt_adv == cw'(slots)) begin
                            hold  <= shift_adv;
                            cnt   <= '0;
                            shreg <= '0;
                            state <= RIGHT;
                        end else begin
                            frame_err <= 1'b1;
                            locked    <= 1'b0;
                            state     <= SYNC;
                        end
                    end
                end
                RIGHT: begin
                    if (lredge) begin
                        if (cnt_adv == cw'(slots)) begin
                            l_data <= hold;
                            r_data <= shift_adv;
                            valid  <= 1'b1;
                            locked <= 1'b1;
                            cnt    <= '0;
                            shreg  <= '0;
                            state  <= LEFT;
                        end else begin
                            frame_err <= 1'b1;
                            locked    <= 1'b0;
                            state     <= SYNC;
                        end
                    end
                end
                default: state <= SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_i2s_in.sv
// Bench for i2s_in: an I2S source model drives sclk/lrclk/sdin, a scoreboard queue holds
// expected stereo pairs, and a negedge monitor checks each valid pulse against it.
module tb_i2s_in;

    logic               clk = 1'b0;
    logic               reset;
    logic               sclk;
    logic               lrclk;
    logic               sdin;
    logic signed [15:0] l_data;
    logic signed [15:0] r_data;
    logic               valid;
    logic               frame_err;
    logic               locked;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          fall_cyc = 0;
    int          vcount = 0;
    int          fecount = 0;
    logic [31:0] sb[$];
    int          vq[$];

    i2s_in #(.dsz(16), .slots(32)) dut (
        .clk(clk), .reset(reset), .sclk(sclk), .lrclk(lrclk), .sdin(sdin),
        .l_data(l_data), .r_data(r_data), .valid(valid),
        .frame_err(frame_err), .locked(locked)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard consumer: every valid must match the oldest queued pair.
    always @(negedge clk) begin
        logic [31:0] exp;
        if (valid) begin
            vcount++;
            vq.push_back(cyc);
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL spurious_valid: got l=%h r=%h, required no valid", l_data, r_data);
            end else begin
                exp = sb.pop_front();
                if ({l_data, r_data} !== exp) begin
                    errors++;
                    $display("FAIL pair_data: got l=%h r=%h, required l=%h r=%h",
                             l_data, r_data, exp[31:16], exp[15:0]);
                end
            end
            checks++;
            if (cyc - fall_cyc !== 4) begin
                errors++;
                $display("FAIL valid_latency: got %0d clk, required 4 clk", cyc - fall_cyc);
            end
        end
        if (frame_err) fecount++;
        if (valid && frame_err) begin
            errors++;
            $display("FAIL valid_and_err: both high at cycle %0d, required exclusive", cyc);
        end
    end

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One half-frame: lrclk changes with the first sclk fall; bit k is sampled on rise k.
    task automatic send_half(input logic lr, input logic [15:0] w, input int unsigned rises);
        for (int unsigned i = 0; i < rises; i++) begin
            sclk = 1'b0;
            if (i == 0) begin
                if (lrclk && !lr) fall_cyc = cyc;
                lrclk = lr;
            end
            if (i >= 1 && i <= 16) sdin = w[16-i];
            else sdin = 1'($urandom_range(1, 0));
            wclk(4);
            sclk = 1'b1;
            wclk(4);
        end
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
        send_half(1'b0, l, 32);
        send_half(1'b1, r, 32);
        sb.push_back({l, r});
    endtask

    task automatic flush();
        sclk = 1'b0;
        if (lrclk) fall_cyc = cyc;
        lrclk = 1'b0;
        wclk(16);
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending pairs, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic start_stream();
        reset = 1'b1;
        wclk(3);
        reset = 1'b0;
        wclk(2);
        send_half(1'b1, 16'h0, 32);
    endtask

    task automatic test_reset();
        reset = 1'b1; sclk = 1'b0; lrclk = 1'b0; sdin = 1'b0;
        wclk(4);
        checks++;
        if ({l_data, r_data, valid, frame_err, locked} !== 35'd0) begin
            errors++;
            $display("FAIL reset_outputs: got l=%h r=%h v=%b e=%b k=%b, required all 0",
                     l_data, r_data, valid, frame_err, locked);
        end
        reset = 1'b0;
        wclk(2);
    endtask

    task automatic test_normal();
        int v0 = vcount;
        start_stream();
        checks++;
        if (locked !== 1'b0) begin
            errors++; $display("FAIL prelock: got %b, required 0", locked);
        end
        send_frame(16'h8001, 16'h7FFE);
        send_frame(16'h8001, 16'h7FFE);
        checks++;
        if (locked !== 1'b1) begin
            errors++; $display("FAIL lock_after_valid: got %b, required 1", locked);
        end
        flush();
        checks++;
        if (vcount - v0 !== 2) begin
            errors++; $display("FAIL normal_count: got %0d valids, required 2", vcount - v0);
        end
    endtask

    task automatic test_startup_midframe();
        int v0 = vcount;
        int f0 = fecount;
        reset = 1'b1;
        send_half(1'b1, 16'h0, 10);
        reset = 1'b0;
        send_half(1'b1, 16'h0, 12);
        checks++;
        if (locked !== 1'b0) begin
            errors++; $display("FAIL startup_lock: got %b, required 0", locked);
        end
        send_frame(16'h1234, 16'hABCD);
        flush();
        checks++;
        if (vcount - v0 !== 1) begin
            errors++; $display("FAIL startup_count: got %0d valids, required 1", vcount - v0);
        end
        checks++;
        if (fecount !== f0) begin
            errors++; $display("FAIL startup_err: got %0d errs, required 0", fecount - f0);
        end
    endtask

    task automatic test_short_half();
        int v0, f0;
        start_stream();
        v0 = vcount;
        f0 = fecount;
        send_frame(16'h5A5A, 16'hC3C3);
        send_half(1'b0, 16'h1111, 20);
        send_half(1'b1, 16'h2222, 32);
        checks++;
        if (fecount - f0 !== 1) begin
            errors++; $display("FAIL short_err: got %0d errs, required 1", fecount - f0);
        end
        checks++;
        if ({l_data, r_data} !== {16'h5A5A, 16'hC3C3}) begin
            errors++;
            $display("FAIL short_hold: got l=%h r=%h, required l=5a5a r=c3c3", l_data, r_data);
        end
        checks++;
        if (locked !== 1'b0) begin
            errors++; $display("FAIL short_unlock: got %b, required 0", locked);
        end
        send_frame(16'h0F0F, 16'hF00F);
        flush();
        checks++;
        if (vcount - v0 !== 2) begin
            errors++; $display("FAIL short_count: got %0d valids, required 2", vcount - v0);
        end
    endtask

    task automatic test_back_to_back();
        start_stream();
        vq.delete();
        for (int i = 0; i < 64; i++) send_frame(16'(i), ~16'(i));
        flush();
        checks++;
        if (vq.size() !== 64) begin
            errors++; $display("FAIL b2b_count: got %0d valids, required 64", vq.size());
        end
        for (int i = 1; i < vq.size(); i++) begin
            checks++;
            if (vq[i] - vq[i-1] !== 512) begin
                errors++;
                $display("FAIL b2b_spacing: got %0d clk at pair %0d, required 512",
                         vq[i] - vq[i-1], i);
            end
        end
    endtask

    task automatic test_extremes();
        int v0;
        start_stream();
        v0 = vcount;
        send_frame(16'h0001, 16'hFFFF);
        send_frame(16'h8000, 16'h0000);
        flush();
        checks++;
        if (vcount - v0 !== 2) begin
            errors++; $display("FAIL extremes_count: got %0d valids, required 2", vcount - v0);
        end
    endtask

    task automatic test_reset_midop();
        int v0;
        start_stream();
        send_frame(16'h7777, 16'h9999);
        send_half(1'b0, 16'h4444, 32);
        send_half(1'b1, 16'h5555, 9);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({l_data, r_data, valid, frame_err, locked} !== 35'd0) begin
            errors++;
            $display("FAIL async_reset: got l=%h r=%h v=%b e=%b k=%b, required all 0",
                     l_data, r_data, valid, frame_err, locked);
        end
        wclk(3);
        reset = 1'b0;
        v0 = vcount;
        send_half(1'b1, 16'h0, 23);
        checks++;
        if ({l_data, r_data} !== 32'd0) begin
            errors++;
            $display("FAIL post_reset_hold: got l=%h r=%h, required 0", l_data, r_data);
        end
        send_frame(16'h3C5A, 16'hA5C3);
        flush();
        checks++;
        if (vcount - v0 !== 1) begin
            errors++; $display("FAIL midop_count: got %0d valids, required 1", vcount - v0);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_startup_midframe();
        test_short_half();
        test_back_to_back();
        test_extremes();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
